spi_apb_arbiter: RTL and testbench
==================================

// Module: spi_apb_arbiter
// PURPOSE
//  Shares one apb2spi bridge between NUM_REQ local requesters. Round-robin arbitration picks
//  one pending request, captures its payload and runs a full APB transfer (SETUP, ACCESS,
//  wait for pready) into the bridge. Returns read data with a per-requester done pulse.
//  A watchdog aborts transfers the SPI side never completes.
// PARAMETERS
//  NUM_REQ         4     number of requesters (>=1)
//  APB_ADDR_WIDTH  16    APB address width
//  APB_DATA_WIDTH  32    APB data width
//  TIMEOUT_CYCLES  1024  max ACCESS cycles before abort; 0 disables the watchdog
// PORTS
//  clk          in   1                      system clock, all logic on rising edge
//  rst          in   1                      synchronous reset, active-high
//  req          in   NUM_REQ                per-requester request level
//  req_write    in   NUM_REQ                1=write, 0=read
//  req_addr     in   NUM_REQ*APB_ADDR_WIDTH packed addresses, requester i at [i*AW +: AW]
//  req_wdata    in   NUM_REQ*APB_DATA_WIDTH packed write data, requester i at [i*DW +: DW]
//  req_gnt      out  NUM_REQ                one-hot 1-cycle pulse: payload captured
//  rsp_done     out  NUM_REQ                one-hot 1-cycle pulse: transfer finished
//  rsp_err      out  1                      valid with rsp_done; 1 = watchdog abort
//  rsp_rdata    out  APB_DATA_WIDTH         read data, valid with rsp_done, held until next done
//  busy         out  1                      high in SETUP and ACCESS
//  apb_sel      out  1                      APB select to bridge
//  apb_penable  out  1                      APB enable
//  apb_pwrite   out  1                      APB direction
//  apb_paddr    out  APB_ADDR_WIDTH         APB address
//  apb_pwdata   out  APB_DATA_WIDTH         APB write data
//  apb_pready   in   1                      bridge ready
//  apb_prdata   in   APB_DATA_WIDTH         bridge read data
// BEHAVIOUR
//  Reset: every output 0; state IDLE; round-robin pointer = 0; watchdog count = 0.
//  All outputs are registered.
//  FSM: IDLE -> SETUP -> ACCESS -> IDLE.
//   IDLE: if any req bit is high at the edge, pick the first set bit scanning from ptr
//     upward (wrapping). Latch its write/addr/wdata onto apb_*. Pulse req_gnt[i].
//     Set ptr = (i+1) mod NUM_REQ. Next state SETUP.
//     In SETUP: apb_sel=1, apb_penable=0, busy=1.
//   SETUP: always one cycle -> ACCESS (apb_sel=1, apb_penable=1).
//   ACCESS: apb_sel/paddr/pwrite/pwdata held stable.
//     If pready is sampled high, return to IDLE. On that transition:
//       - apb_sel=0, apb_penable=0; paddr and pwdata cleared to 0.
//       - rsp_done[i] pulses, rsp_err=0.
//       - rsp_rdata = apb_prdata on reads; unchanged on writes.
//  Watchdog: the counter clears on entry to ACCESS and increments every ACCESS cycle
//    with pready low. If pready is low while count==TIMEOUT_CYCLES-1, abort to IDLE:
//    APB signals drop as above, rsp_done[i] pulses, rsp_err=1, rsp_rdata=0.
//    So ACCESS lasts at most TIMEOUT_CYCLES cycles.
//  Simultaneous pready and timeout in the same cycle: pready wins; success, err=0.
//  Requester rules:
//    - Hold req and payload until req_gnt. Only the granted payload is sampled.
//    - A req dropped before grant is simply never served.
//    - req still high after rsp_done is treated as a new request.
//    - Requests arriving while busy wait; nothing is queued beyond the req level.
//  Spacing: at least one IDLE cycle between transfers. Gap from done to next SETUP = 1 cycle.
//  Reset mid-transfer: the in-flight transfer is dropped with no rsp_done and APB
//    deasserts in the same cycle.
// TESTING
//  1 Write: req[0], write, addr 16'ha579, wdata 32'ha37743f3; bridge pready after 600 cycles
//    -> gnt[0] pulse, SETUP 1 cycle, ACCESS held stable, rsp_done[0] err=0, apb_sel low after.
//  2 Read: req[1], read, addr 16'hb843; pready with prdata 32'h6547c3d5 after 540 cycles
//    -> rsp_done[1], rsp_rdata=32'h6547c3d5, err=0.
//  3 Fairness: req[3:0]=4'hF held, pready 3 cycles into ACCESS -> grants 0,1,2,3,0.
//    Then with only req[2] and req[0] high and ptr=1 -> grant 2 before 0.
//  4 Watchdog: TIMEOUT_CYCLES=16, pready stuck 0 -> ACCESS lasts exactly 16 cycles,
//    rsp_done with err=1, rdata=0. Repeat with pready on cycle 16 -> err=0.
//  5 Reset: assert rst in ACCESS cycle 5 -> next cycle all outputs 0, no rsp_done,
//    ptr=0; a new req[2] afterwards is served normally.
//  6 Drop: req[3] pulses 1 cycle while busy -> never granted; no rsp_done[3].

Source files
------------

// File: rtl/spi_apb_arbiter.sv
// Round-robin arbiter that shares one APB-to-SPI bridge among NUM_REQ local requesters,
// with an ACCESS-phase watchdog that aborts transfers the bridge never completes.
module spi_apb_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned APB_ADDR_WIDTH = 16,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ-1:0]                req_write,
    input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*APB_DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]                req_gnt,
    output logic [NUM_REQ-1:0]                rsp_done,
    output logic                              rsp_err,
    output logic [APB_DATA_WIDTH-1:0]         rsp_rdata,
    output logic                              busy,
    output logic                              apb_sel,
    output logic                              apb_penable,
    output logic                              apb_pwrite,
    output logic [APB_ADDR_WIDTH-1:0]         apb_paddr,
    output logic [APB_DATA_WIDTH-1:0]         apb_pwdata,
    input  logic                              apb_pready,
    input  logic [APB_DATA_WIDTH-1:0]         apb_prdata
);

    localparam int unsigned AW      = APB_ADDR_WIDTH;
    localparam int unsigned DW      = APB_DATA_WIDTH;
    localparam int unsigned PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam int unsigned WD_LAST = WD_EN ? (TIMEOUT_CYCLES - 1) : 0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       owner_q, owner_d;
    logic [CW-1:0]       wd_cnt_q, wd_cnt_d;
    logic [NUM_REQ-1:0]  req_gnt_q, req_gnt_d;
    logic [NUM_REQ-1:0]  rsp_done_q, rsp_done_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DW-1:0]       rsp_rdata_q, rsp_rdata_d;
    logic                busy_q, busy_d;
    logic                sel_q, sel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [AW-1:0]       paddr_q, paddr_d;
    logic [DW-1:0]       pwdata_q, pwdata_d;

    logic                any_req;
    logic [PW-1:0]       pick;
    logic [PW-1:0]       pick_next;

    // First pending request at or after ptr_q, wrapping around.
    always_comb begin
        int unsigned j;
        logic [PW-1:0] jj;
        any_req   = 1'b0;
        pick      = '0;
        pick_next = '0;
        j         = 0;
        jj        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = 32'(ptr_q) + k;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            jj = PW'(j);
            if (!any_req && req[jj]) begin
                any_req   = 1'b1;
                pick      = jj;
                pick_next = PW'((j + 1 == NUM_REQ) ? 32'd0 : j + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            wd_cnt_q    <= '0;
            req_gnt_q   <= '0;
            rsp_done_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
            sel_q       <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            wd_cnt_q    <= wd_cnt_d;
            req_gnt_q   <= req_gnt_d;
            rsp_done_q  <= rsp_done_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            busy_q      <= busy_d;
            sel_q       <= sel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        wd_cnt_d    = wd_cnt_q;
        req_gnt_d   = '0;
        rsp_done_d  = '0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        busy_d      = busy_q;
        sel_d       = sel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d         = S_SETUP;
                    owner_d         = pick;
                    ptr_d           = pick_next;
                    req_gnt_d[pick] = 1'b1;
                    pwrite_d        = req_write[pick];
                    paddr_d         = req_addr[32'(pick) * AW +: AW];
                    pwdata_d        = req_wdata[32'(pick) * DW +: DW];
                    sel_d           = 1'b1;
                    penable_d       = 1'b0;
                    busy_d          = 1'b1;
                end
            end
            S_SETUP: begin
                state_d   = S_ACCESS;
                penable_d = 1'b1;
                wd_cnt_d  = '0;
            end
            S_ACCESS: begin
                // pready takes priority over a watchdog expiry in the same cycle.
                if (apb_pready || (WD_EN && (wd_cnt_q == CW'(WD_LAST)))) begin
                    state_d             = S_IDLE;
                    sel_d               = 1'b0;
                    penable_d           = 1'b0;
                    busy_d              = 1'b0;
                    paddr_d             = '0;
                    pwdata_d            = '0;
                    rsp_done_d[owner_q] = 1'b1;
                    if (apb_pready) begin
                        if (!pwrite_q) begin
                            rsp_rdata_d = apb_prdata;
                        end
                    end else begin
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end else if (WD_EN) begin
                    wd_cnt_d = wd_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_gnt     = req_gnt_q;
    assign rsp_done    = rsp_done_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign busy        = busy_q;
    assign apb_sel     = sel_q;
    assign apb_penable = penable_q;
    assign apb_pwrite  = pwrite_q;
    assign apb_paddr   = paddr_q;
    assign apb_pwdata  = pwdata_q;

endmodule

// File: tb/tb_spi_apb_arbiter.sv
// Bench for spi_apb_arbiter: table-driven transfers on a default instance plus hand-written
// reset, drop and watchdog sequences (the watchdog runs on a second instance with a short timeout).
module tb_spi_apb_arbiter;

    logic clk;
    logic rst;

    // Main instance (TIMEOUT_CYCLES = 1024)
    logic [3:0]  req, req_write, gnt, done;
    logic [63:0] addr_bus;
    logic [127:0] wdata_bus;
    logic        err, busy, sel, pen, pwrite, pready;
    logic [31:0] rdata, pwdata, prdata;
    logic [15:0] paddr;

    // Watchdog instance (TIMEOUT_CYCLES = 16)
    logic [3:0]  w_req, w_wr, w_gnt, w_done;
    logic        w_err, w_busy, w_sel, w_pen, w_pwrite, w_pready;
    logic [31:0] w_rdata, w_pwdata, w_prdata;
    logic [15:0] w_paddr;

    int checks;
    int errors;

    spi_apb_arbiter u_dut (
        .clk(clk), .rst(rst),
        .req(req), .req_write(req_write), .req_addr(addr_bus), .req_wdata(wdata_bus),
        .req_gnt(gnt), .rsp_done(done), .rsp_err(err), .rsp_rdata(rdata), .busy(busy),
        .apb_sel(sel), .apb_penable(pen), .apb_pwrite(pwrite), .apb_paddr(paddr),
        .apb_pwdata(pwdata), .apb_pready(pready), .apb_prdata(prdata)
    );

    spi_apb_arbiter #(
        .NUM_REQ(4), .APB_ADDR_WIDTH(16), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
    ) u_wd (
        .clk(clk), .rst(rst),
        .req(w_req), .req_write(w_wr), .req_addr(addr_bus), .req_wdata(wdata_bus),
        .req_gnt(w_gnt), .rsp_done(w_done), .rsp_err(w_err), .rsp_rdata(w_rdata), .busy(w_busy),
        .apb_sel(w_sel), .apb_penable(w_pen), .apb_pwrite(w_pwrite), .apb_paddr(w_paddr),
        .apb_pwdata(w_pwdata), .apb_pready(w_pready), .apb_prdata(w_prdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst_before;
        logic [3:0]  req;
        logic [3:0]  wr;
        int          wait_cyc;
        logic [31:0] prd;
        int          exp_idx;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [11];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        req = '0; req_write = '0; pready = 1'b0; prdata = '0;
        w_req = '0; w_wr = '0; w_pready = 1'b0; w_prdata = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // One complete transfer: request, SETUP, ACCESS held for wait_cyc cycles, then pready.
    task automatic xfer(input vec_t v, input int id);
        logic [3:0] one;
        logic [3:0] g;
        int bad;
        if (v.rst_before) do_reset();
        one = 4'b0001;
        g = one << v.exp_idx;
        req = v.req; req_write = v.wr; prdata = v.prd; pready = 1'b0;
        step();
        chk($sformatf("v%0d gnt", id), gnt, g);
        chk($sformatf("v%0d setup sel/pen/busy", id), {sel, pen, busy}, 3'b101);
        chk($sformatf("v%0d paddr", id), paddr, addr_bus[v.exp_idx*16 +: 16]);
        chk($sformatf("v%0d pwdata", id), pwdata, wdata_bus[v.exp_idx*32 +: 32]);
        chk($sformatf("v%0d pwrite", id), pwrite, v.wr[v.exp_idx]);
        chk($sformatf("v%0d done quiet", id), done, 4'b0000);
        req = v.req & ~g;
        step();
        chk($sformatf("v%0d access", id), {sel, pen, gnt}, 6'b110000);
        bad = 0;
        for (int k = 1; k <= v.wait_cyc; k++) begin
            if (!(sel && pen && busy && done == 4'b0000 &&
                  paddr == addr_bus[v.exp_idx*16 +: 16] &&
                  pwdata == wdata_bus[v.exp_idx*32 +: 32] &&
                  pwrite == v.wr[v.exp_idx])) bad++;
            step();
        end
        chk($sformatf("v%0d access stable", id), bad, 0);
        pready = 1'b1;
        step();
        pready = 1'b0;
        req = '0;
        chk($sformatf("v%0d done", id), done, g);
        chk($sformatf("v%0d err", id), err, 1'b0);
        chk($sformatf("v%0d rdata", id), rdata, v.exp_rdata);
        chk($sformatf("v%0d idle apb", id), {sel, pen, busy, paddr, pwdata}, 51'd0);
    endtask

    // Counts ACCESS cycles on the watchdog instance; optionally raises pready in cycle 16.
    task automatic wd_run(input bit give_ready, output int len);
        int n;
        n = 0;
        while (w_sel && w_pen && n < 40) begin
            n++;
            w_pready = give_ready && (n == 16);
            step();
        end
        w_pready = 1'b0;
        len = n;
    endtask

    initial begin
        int bad;
        int len;
        checks = 0;
        errors = 0;
        addr_bus  = {16'h4d10, 16'h3c21, 16'hb843, 16'ha579};
        wdata_bus = {32'h0badf00d, 32'h9abcdef0, 32'h12345678, 32'ha37743f3};

        //            rst  req      wr       wait prdata        idx rdata
        vecs[0]  = '{1'b1, 4'b0001, 4'b0001, 600, 32'hdeadbeef, 0, 32'h00000000};
        vecs[1]  = '{1'b0, 4'b0010, 4'b0000, 540, 32'h6547c3d5, 1, 32'h6547c3d5};
        vecs[2]  = '{1'b1, 4'b1111, 4'b0101, 2,   32'h11111111, 0, 32'h00000000};
        vecs[3]  = '{1'b0, 4'b1111, 4'b0101, 2,   32'h22222222, 1, 32'h22222222};
        vecs[4]  = '{1'b0, 4'b1111, 4'b0101, 2,   32'h33333333, 2, 32'h22222222};
        vecs[5]  = '{1'b0, 4'b1111, 4'b0101, 2,   32'h44444444, 3, 32'h44444444};
        vecs[6]  = '{1'b0, 4'b1111, 4'b0101, 2,   32'h55555555, 0, 32'h44444444};
        vecs[7]  = '{1'b0, 4'b0101, 4'b0000, 2,   32'h66666666, 2, 32'h66666666};
        vecs[8]  = '{1'b0, 4'b0101, 4'b0000, 2,   32'h77777777, 0, 32'h77777777};
        vecs[9]  = '{1'b0, 4'b1010, 4'b0000, 3,   32'h88888888, 1, 32'h88888888};
        vecs[10] = '{1'b0, 4'b0100, 4'b0100, 5,   32'h99999999, 2, 32'h88888888};

        do_reset();
        step();
        chk("reset ctrl", {gnt, done, err, busy, sel, pen, pwrite}, 13'd0);
        chk("reset data", {rdata, paddr, pwdata}, 80'd0);
        chk("reset wd inst", {w_gnt, w_done, w_err, w_busy, w_sel, w_pen, w_rdata}, 45'd0);

        for (int i = 0; i <= 8; i++) xfer(vecs[i], i);

        // Reset in ACCESS cycle 5: transfer dropped, no done, pointer back to 0.
        req = 4'b0100; req_write = 4'b0100;
        step();
        chk("midrst gnt", gnt, 4'b0100);
        req = '0;
        step();
        for (int k = 1; k < 5; k++) step();
        chk("midrst access5", {sel, pen, busy}, 3'b111);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst ctrl", {gnt, done, err, busy, sel, pen, pwrite}, 13'd0);
        chk("midrst data", {rdata, paddr, pwdata}, 80'd0);
        bad = 0;
        for (int k = 0; k < 4; k++) begin
            if (done != 4'b0000 || busy) bad++;
            step();
        end
        chk("midrst no done", bad, 0);
        xfer(vecs[9], 9);
        xfer(vecs[10], 10);

        // req[3] pulses for one cycle while busy and must never be served.
        req = 4'b0001; req_write = 4'b0001;
        step();
        chk("drop gnt0", gnt, 4'b0001);
        req = '0;
        step();
        req = 4'b1000;
        step();
        req = '0;
        step();
        pready = 1'b1;
        step();
        pready = 1'b0;
        chk("drop done0", done, 4'b0001);
        chk("drop rdata held", rdata, 32'h88888888);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (gnt != 4'b0000 || done != 4'b0000 || busy) bad++;
        end
        chk("drop never served", bad, 0);

        // Watchdog: pready arriving in ACCESS cycle 16 still succeeds.
        w_req = 4'b0001; w_wr = 4'b0000; w_prdata = 32'hcafef00d;
        step();
        chk("wd gnt0", w_gnt, 4'b0001);
        w_req = '0;
        step();
        wd_run(1'b1, len);
        chk("wd ready@16 len", len, 16);
        chk("wd ready@16 done", w_done, 4'b0001);
        chk("wd ready@16 err", w_err, 1'b0);
        chk("wd ready@16 rdata", w_rdata, 32'hcafef00d);
        step();

        // Watchdog: pready stuck low aborts after exactly 16 ACCESS cycles.
        w_req = 4'b0010; w_wr = 4'b0000; w_prdata = 32'h5a5a5a5a;
        step();
        chk("wd gnt1", w_gnt, 4'b0010);
        w_req = '0;
        step();
        wd_run(1'b0, len);
        chk("wd abort len", len, 16);
        chk("wd abort done", w_done, 4'b0010);
        chk("wd abort err", w_err, 1'b1);
        chk("wd abort rdata", w_rdata, 32'h00000000);
        chk("wd abort apb", {w_sel, w_pen, w_busy, w_paddr, w_pwdata}, 51'd0);
        step();
        chk("wd done pulse", {w_done, w_err}, 5'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
